// File: rtl/pipe_wb_queue.sv
// pipe_wb_queue: writeback stage with a DEPTH-entry in-order queue between MEM and
// the regfile/CSR/TLB side. Retires at most one entry per cycle, honours an
// external retire stall, priority-encodes exceptions and counts retired instructions.
// Optional feature macro: WB_TRACE_EN adds the debug_wb_* retire trace ports.
module pipe_wb_queue #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    // MEM side
    input  logic              from_valid,
    output logic              to_allowin,
    input  logic [31:0]       from_pc,
    input  logic              rf_we_MEM,
    input  logic [RA_W-1:0]   rf_waddr_MEM,
    input  logic [DATA_W-1:0] rf_wdata_MEM,
    input  logic              csr_rd_MEM,
    input  logic              csr_we_MEM,
    input  logic [13:0]       csr_num_MEM,
    input  logic [DATA_W-1:0] csr_wmask_MEM,
    input  logic [DATA_W-1:0] csr_wdata_MEM,
    input  logic              ertn_MEM,
    input  logic              refetch_MEM,
    input  logic [13:0]       exc_MEM,
    input  logic [31:0]       vaddr_MEM,
    // retire side
    input  logic              retire_stall,
    input  logic [DATA_W-1:0] csr_rvalue,
    output logic              to_valid,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              csr_we,
    output logic [13:0]       csr_num,
    output logic [DATA_W-1:0] csr_wmask,
    output logic [DATA_W-1:0] csr_wdata,
    output logic              ertn_flush,
    output logic              wb_ex,
    output logic [5:0]        wb_ecode,
    output logic [8:0]        wb_esubcode,
    output logic [31:0]       wb_vaddr,
    output logic [31:0]       wb_pc,
    output logic              refetch_flush,
`ifdef WB_TRACE_EN
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_we,
    output logic [RA_W-1:0]   debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata,
`endif
    output logic [63:0]       instret
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // exc_MEM bit positions
    localparam int unsigned EX_INT     = 0;
    localparam int unsigned EX_PIL     = 1;
    localparam int unsigned EX_PIS     = 2;
    localparam int unsigned EX_PIF     = 3;
    localparam int unsigned EX_PME     = 4;
    localparam int unsigned EX_PPI_EX  = 5;
    localparam int unsigned EX_PPI_IF  = 6;
    localparam int unsigned EX_ADEF    = 7;
    localparam int unsigned EX_ALE     = 8;
    localparam int unsigned EX_SYS     = 9;
    localparam int unsigned EX_BRK     = 10;
    localparam int unsigned EX_INE     = 11;
    localparam int unsigned EX_TLBR_EX = 12;
    localparam int unsigned EX_TLBR_IF = 13;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;
    localparam logic [8:0] ESUBCODE_ADEF = 9'h000;

    // queue storage, one array per field
    logic [31:0]       pc_q        [DEPTH];
    logic              rf_we_q     [DEPTH];
    logic [RA_W-1:0]   rf_waddr_q  [DEPTH];
    logic [DATA_W-1:0] rf_wdata_q  [DEPTH];
    logic              csr_rd_q    [DEPTH];
    logic              csr_we_q    [DEPTH];
    logic [13:0]       csr_num_q   [DEPTH];
    logic [DATA_W-1:0] csr_wmask_q [DEPTH];
    logic [DATA_W-1:0] csr_wdata_q [DEPTH];
    logic              ertn_q      [DEPTH];
    logic              refetch_q   [DEPTH];
    logic [13:0]       exc_q       [DEPTH];
    logic [31:0]       vaddr_q     [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [63:0]      instret_q;

    logic push;
    logic fire;
    logic head_refetch;
    logic head_exc;
    logic head_ertn;
    logic flush;
    logic [13:0] head_exc_vec;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign to_allowin = (count_q != CNT_W'(DEPTH));
    assign to_valid   = (count_q != '0);
    assign push       = from_valid & to_allowin;
    assign fire       = to_valid & ~retire_stall;

    assign head_exc_vec = exc_q[rd_ptr_q];
    assign head_refetch = refetch_q[rd_ptr_q];
    assign head_exc     = (|head_exc_vec) & ~head_refetch;
    assign head_ertn    = ertn_q[rd_ptr_q] & ~head_refetch & ~head_exc;
    assign flush        = fire & (head_refetch | head_exc | head_ertn);

    // head data outputs, side effects gated by fire and by precedence
    assign rf_we         = fire & rf_we_q[rd_ptr_q] & ~head_refetch & ~head_exc;
    assign rf_waddr      = rf_waddr_q[rd_ptr_q];
    assign rf_wdata      = csr_rd_q[rd_ptr_q] ? csr_rvalue : rf_wdata_q[rd_ptr_q];
    assign csr_we        = fire & csr_we_q[rd_ptr_q] & ~head_refetch & ~head_exc;
    assign csr_num       = csr_num_q[rd_ptr_q];
    assign csr_wmask     = csr_wmask_q[rd_ptr_q];
    assign csr_wdata     = csr_wdata_q[rd_ptr_q];
    assign ertn_flush    = fire & head_ertn;
    assign wb_ex         = fire & head_exc;
    assign refetch_flush = fire & head_refetch;
    assign wb_esubcode   = ESUBCODE_ADEF;
    assign wb_vaddr      = vaddr_q[rd_ptr_q];
    assign wb_pc         = pc_q[rd_ptr_q];
    assign instret       = instret_q;

`ifdef WB_TRACE_EN
    assign debug_wb_pc       = wb_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

    // single exception code from the head's exception vector, highest priority wins
    always_comb begin
        wb_ecode = ECODE_INT;
        if      (head_exc_vec[EX_INT])     wb_ecode = ECODE_INT;
        else if (head_exc_vec[EX_ADEF])    wb_ecode = ECODE_ADE;
        else if (head_exc_vec[EX_TLBR_IF]) wb_ecode = ECODE_TLBR;
        else if (head_exc_vec[EX_PIF])     wb_ecode = ECODE_PIF;
        else if (head_exc_vec[EX_PPI_IF])  wb_ecode = ECODE_PPI;
        else if (head_exc_vec[EX_INE])     wb_ecode = ECODE_INE;
        else if (head_exc_vec[EX_SYS])     wb_ecode = ECODE_SYS;
        else if (head_exc_vec[EX_BRK])     wb_ecode = ECODE_BRK;
        else if (head_exc_vec[EX_ALE])     wb_ecode = ECODE_ALE;
        else if (head_exc_vec[EX_TLBR_EX]) wb_ecode = ECODE_TLBR;
        else if (head_exc_vec[EX_PIL])     wb_ecode = ECODE_PIL;
        else if (head_exc_vec[EX_PIS])     wb_ecode = ECODE_PIS;
        else if (head_exc_vec[EX_PME])     wb_ecode = ECODE_PME;
        else if (head_exc_vec[EX_PPI_EX])  wb_ecode = ECODE_PPI;
    end

    // queue storage write on push; a flushing retire drops the same-cycle push
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]        <= '0;
                rf_we_q[i]     <= 1'b0;
                rf_waddr_q[i]  <= '0;
                rf_wdata_q[i]  <= '0;
                csr_rd_q[i]    <= 1'b0;
                csr_we_q[i]    <= 1'b0;
                csr_num_q[i]   <= '0;
                csr_wmask_q[i] <= '0;
                csr_wdata_q[i] <= '0;
                ertn_q[i]      <= 1'b0;
                refetch_q[i]   <= 1'b0;
                exc_q[i]       <= '0;
                vaddr_q[i]     <= '0;
            end
        end else if (push && !flush) begin
            pc_q[wr_ptr_q]        <= from_pc;
            rf_we_q[wr_ptr_q]     <= rf_we_MEM;
            rf_waddr_q[wr_ptr_q]  <= rf_waddr_MEM;
            rf_wdata_q[wr_ptr_q]  <= rf_wdata_MEM;
            csr_rd_q[wr_ptr_q]    <= csr_rd_MEM;
            csr_we_q[wr_ptr_q]    <= csr_we_MEM;
            csr_num_q[wr_ptr_q]   <= csr_num_MEM;
            csr_wmask_q[wr_ptr_q] <= csr_wmask_MEM;
            csr_wdata_q[wr_ptr_q] <= csr_wdata_MEM;
            ertn_q[wr_ptr_q]      <= ertn_MEM;
            refetch_q[wr_ptr_q]   <= refetch_MEM;
            exc_q[wr_ptr_q]       <= exc_MEM;
            vaddr_q[wr_ptr_q]     <= vaddr_MEM;
        end
    end

    // pointers and occupancy; flush empties the queue
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (fire) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !fire) begin
                count_q <= count_q + CNT_W'(1);
            end else if (fire && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // retired-instruction counter; refetch and exception retires do not count
    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else if (fire && !head_refetch && !head_exc) begin
            instret_q <= instret_q + 64'd1;
        end
    end

endmodule

// File: tb/tb_pipe_wb_queue.sv
// Scoreboard bench for pipe_wb_queue: stimulus pushes expected retires into a queue,
// a negedge monitor pops and compares whenever the DUT retires an entry.
module tb_pipe_wb_queue;

    logic        clk;
    logic        reset;
    logic        from_valid;
    logic        to_allowin;
    logic [31:0] from_pc;
    logic        rf_we_MEM;
    logic [4:0]  rf_waddr_MEM;
    logic [31:0] rf_wdata_MEM;
    logic        csr_rd_MEM;
    logic        csr_we_MEM;
    logic [13:0] csr_num_MEM;
    logic [31:0] csr_wmask_MEM;
    logic [31:0] csr_wdata_MEM;
    logic        ertn_MEM;
    logic        refetch_MEM;
    logic [13:0] exc_MEM;
    logic [31:0] vaddr_MEM;
    logic        retire_stall;
    logic [31:0] csr_rvalue;
    logic        to_valid;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic        ertn_flush;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_vaddr;
    logic [31:0] wb_pc;
    logic        refetch_flush;
    logic [63:0] instret;

    pipe_wb_queue #(.DEPTH(2), .DATA_W(32), .RA_W(5)) dut (
        .clk(clk), .reset(reset),
        .from_valid(from_valid), .to_allowin(to_allowin), .from_pc(from_pc),
        .rf_we_MEM(rf_we_MEM), .rf_waddr_MEM(rf_waddr_MEM), .rf_wdata_MEM(rf_wdata_MEM),
        .csr_rd_MEM(csr_rd_MEM), .csr_we_MEM(csr_we_MEM), .csr_num_MEM(csr_num_MEM),
        .csr_wmask_MEM(csr_wmask_MEM), .csr_wdata_MEM(csr_wdata_MEM),
        .ertn_MEM(ertn_MEM), .refetch_MEM(refetch_MEM), .exc_MEM(exc_MEM), .vaddr_MEM(vaddr_MEM),
        .retire_stall(retire_stall), .csr_rvalue(csr_rvalue),
        .to_valid(to_valid), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wdata(csr_wdata),
        .ertn_flush(ertn_flush), .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_vaddr(wb_vaddr), .wb_pc(wb_pc), .refetch_flush(refetch_flush), .instret(instret)
    );

    localparam logic [13:0] X_INT = 14'h0001, X_PIL = 14'h0002, X_PIS = 14'h0004;
    localparam logic [13:0] X_PIF = 14'h0008, X_PME = 14'h0010, X_PPI_EX = 14'h0020;
    localparam logic [13:0] X_ADEF = 14'h0080, X_ALE = 14'h0100;
    localparam logic [13:0] X_INE = 14'h0800, X_TLBR_EX = 14'h1000, X_TLBR_IF = 14'h2000;

    typedef struct {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wdata;
        logic        ertn;
        logic        ex;
        logic [5:0]  ecode;
        logic        refetch;
        logic [31:0] vaddr;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // exception priority vectors and their hand-encoded ecodes
    logic [13:0] exc_tab   [7] = '{X_INT | X_ALE, X_ALE | X_PIL, X_TLBR_EX | X_INE, X_ADEF | X_TLBR_IF,
                                   X_PIS | X_PME, X_PPI_EX, X_TLBR_IF | X_PIF};
    logic [5:0]  ecode_tab [7] = '{6'h00, 6'h09, 6'h0D, 6'h08, 6'h02, 6'h07, 6'h3F};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ret(input logic [31:0] pc, input logic rfwe, input logic [4:0] wa,
                              input logic [31:0] wd, input logic cwe, input logic [13:0] cnum,
                              input logic [31:0] cwd, input logic ert, input logic ex,
                              input logic [5:0] ec, input logic rfch, input logic [31:0] va);
        exp_t e;
        e.pc = pc; e.rf_we = rfwe; e.waddr = wa; e.wdata = wd; e.csr_we = cwe;
        e.csr_num = cnum; e.csr_wdata = cwd; e.ertn = ert; e.ex = ex; e.ecode = ec;
        e.refetch = rfch; e.vaddr = va;
        exp_q.push_back(e);
    endtask

    task automatic set_in(input logic [31:0] pc, input logic rfwe, input logic [4:0] wa,
                          input logic [31:0] wd, input logic crd, input logic cwe,
                          input logic [13:0] cnum, input logic [31:0] cwd, input logic ert,
                          input logic rfch, input logic [13:0] exc, input logic [31:0] va);
        from_pc = pc; rf_we_MEM = rfwe; rf_waddr_MEM = wa; rf_wdata_MEM = wd;
        csr_rd_MEM = crd; csr_we_MEM = cwe; csr_num_MEM = cnum; csr_wdata_MEM = cwd;
        ertn_MEM = ert; refetch_MEM = rfch; exc_MEM = exc; vaddr_MEM = va;
    endtask

    // hold from_valid until the entry is accepted on a clock edge (bounded)
    task automatic push_wait();
        int n = 0;
        from_valid = 1'b1;
        while (!to_allowin && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!to_allowin) begin
            checks++; errors++;
            $display("FAIL allowin_timeout: got to_allowin=0 expected 1 within 50 cycles");
        end
        @(posedge clk); #1;
        from_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (to_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 64'(to_valid), 64'd0);
    endtask

    // monitor: compare every retire against the scoreboard head
    always @(negedge clk) begin
        if (!reset && to_valid && !retire_stall) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_retire: got pc 0x%0h expected no retire", wb_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_pc", 64'(wb_pc), 64'(e.pc));
                chk("rf_we", 64'(rf_we), 64'(e.rf_we));
                if (e.rf_we) begin
                    chk("rf_waddr", 64'(rf_waddr), 64'(e.waddr));
                    chk("rf_wdata", 64'(rf_wdata), 64'(e.wdata));
                end
                chk("csr_we", 64'(csr_we), 64'(e.csr_we));
                if (e.csr_we) begin
                    chk("csr_num", 64'(csr_num), 64'(e.csr_num));
                    chk("csr_wdata", 64'(csr_wdata), 64'(e.csr_wdata));
                end
                chk("ertn_flush", 64'(ertn_flush), 64'(e.ertn));
                chk("wb_ex", 64'(wb_ex), 64'(e.ex));
                if (e.ex) begin
                    chk("wb_ecode", 64'(wb_ecode), 64'(e.ecode));
                    chk("wb_esubcode", 64'(wb_esubcode), 64'd0);
                    chk("wb_vaddr", 64'(wb_vaddr), 64'(e.vaddr));
                end
                chk("refetch_flush", 64'(refetch_flush), 64'(e.refetch));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; from_valid = 1'b0; retire_stall = 1'b0;
        csr_rvalue = 32'h0000_ABCD; csr_wmask_MEM = 32'hFFFF_FFFF;
        set_in(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
        idle(2);
        reset = 1'b0;

        // reset state
        chk("rst_to_valid", 64'(to_valid), 64'd0);
        chk("rst_to_allowin", 64'(to_allowin), 64'd1);
        chk("rst_instret", instret, 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_wb_pc", 64'(wb_pc), 64'd0);
        chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);

        // single add, retires the cycle after the push
        expect_ret(32'h1c00_0000, 1'b1, 5'd3, 32'd5, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 6'h0, 1'b0, 32'h0);
        set_in(32'h1c00_0000, 1'b1, 5'd3, 32'd5, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
        push_wait();
        idle(1);
        chk("add_instret", instret, 64'd1);

        // backpressure with a stalled head, then in-order release
        retire_stall = 1'b1;
        expect_ret(32'h1c00_0010, 1'b1, 5'd4, 32'h11, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 6'h0, 1'b0, 32'h0);
        set_in(32'h1c00_0010, 1'b1, 5'd4, 32'h11, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
        push_wait();
        expect_ret(32'h1c00_0014, 1'b1, 5'd5, 32'h22, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 6'h0, 1'b0, 32'h0);
        set_in(32'h1c00_0014, 1'b1, 5'd5, 32'h22, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
        push_wait();
        chk("full_allowin", 64'(to_allowin), 64'd0);
        expect_ret(32'h1c00_0018, 1'b1, 5'd6, 32'h33, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 6'h0, 1'b0, 32'h0);
        set_in(32'h1c00_0018, 1'b1, 5'd6, 32'h33, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
        from_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            idle(1);
            chk("stall_allowin", 64'(to_allowin), 64'd0);
            chk("stall_head_pc", 64'(wb_pc), 64'h1c00_0010);
        end
        retire_stall = 1'b0;
        push_wait();
        wait_drain();
        chk("bp_instret", instret, 64'd4);

        // exception with a trailing push that the flush must drop
        expect_ret(32'h1c00_0100, 1'b0, 5'd0, 32'h0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b1, 6'h00, 1'b0, 32'hdead_0000);
        set_in(32'h1c00_0100, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, X_INT | X_ALE, 32'hdead_0000);
        push_wait();
        set_in(32'h1c00_0104, 1'b1, 5'd8, 32'h88, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
        push_wait();
        chk("exc_flush_empty", 64'(to_valid), 64'd0);

        // ecode priority table, one exception per retire
        for (int i = 0; i < 7; i++) begin
            expect_ret(32'h1c00_0200 + 32'(i * 4), 1'b0, 5'd0, 32'h0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b1,
                       ecode_tab[i], 1'b0, 32'h0000_1000 + 32'(i));
            set_in(32'h1c00_0200 + 32'(i * 4), 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 14'h1, 32'h1, 1'b0, 1'b0,
                   exc_tab[i], 32'h0000_1000 + 32'(i));
            push_wait();
            idle(1);
        end
        chk("exc_instret", instret, 64'd4);

        // refetch wins over exception and does not count
        expect_ret(32'h1c00_0300, 1'b0, 5'd0, 32'h0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 6'h0, 1'b1, 32'h0);
        set_in(32'h1c00_0300, 1'b1, 5'd10, 32'h10, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b1, X_INT, 32'h0);
        push_wait();
        idle(1);
        chk("refetch_empty", 64'(to_valid), 64'd0);
        chk("refetch_instret", instret, 64'd4);

        // csrrd: csr_num visible while stalled, data taken from csr_rvalue at retire
        retire_stall = 1'b1;
        expect_ret(32'h1c00_0400, 1'b1, 5'd7, 32'h0000_ABCD, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 6'h0, 1'b0, 32'h0);
        set_in(32'h1c00_0400, 1'b1, 5'd7, 32'h1111, 1'b1, 1'b0, 14'h0005, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
        push_wait();
        chk("stalled_csr_num", 64'(csr_num), 64'h5);
        chk("stalled_rf_we", 64'(rf_we), 64'd0);
        retire_stall = 1'b0;
        // csrwr
        expect_ret(32'h1c00_0404, 1'b0, 5'd0, 32'h0, 1'b1, 14'h0006, 32'h1234, 1'b0, 1'b0, 6'h0, 1'b0, 32'h0);
        set_in(32'h1c00_0404, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 14'h0006, 32'h1234, 1'b0, 1'b0, 14'h0, 32'h0);
        push_wait();
        wait_drain();
        chk("csr_instret", instret, 64'd6);

        // ertn counts, flushes and drops the trailing push
        expect_ret(32'h1c00_0500, 1'b0, 5'd0, 32'h0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 6'h0, 1'b0, 32'h0);
        set_in(32'h1c00_0500, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 14'h0, 32'h0);
        push_wait();
        set_in(32'h1c00_0504, 1'b1, 5'd1, 32'h1, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
        push_wait();
        chk("ertn_empty", 64'(to_valid), 64'd0);
        chk("ertn_instret", instret, 64'd7);

        // back-to-back stream exercising pointer wrap
        for (int i = 0; i < 4; i++) begin
            expect_ret(32'h1c00_0600 + 32'(i * 4), 1'b1, 5'(i + 12), 32'h100 + 32'(i), 1'b0, 14'h0, 32'h0,
                       1'b0, 1'b0, 6'h0, 1'b0, 32'h0);
            set_in(32'h1c00_0600 + 32'(i * 4), 1'b1, 5'(i + 12), 32'h100 + 32'(i), 1'b0, 1'b0, 14'h0, 32'h0,
                   1'b0, 1'b0, 14'h0, 32'h0);
            push_wait();
        end
        wait_drain();
        chk("stream_instret", instret, 64'd11);

        // reset with two queued entries: nothing retires, state cleared
        retire_stall = 1'b1;
        set_in(32'h1c00_0700, 1'b1, 5'd2, 32'h2, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
        push_wait();
        set_in(32'h1c00_0704, 1'b1, 5'd3, 32'h3, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
        push_wait();
        chk("pre_rst_valid", 64'(to_valid), 64'd1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("mid_rst_to_valid", 64'(to_valid), 64'd0);
        chk("mid_rst_instret", instret, 64'd0);
        chk("mid_rst_allowin", 64'(to_allowin), 64'd1);
        chk("mid_rst_wb_pc", 64'(wb_pc), 64'd0);
        retire_stall = 1'b0;
        chk("mid_rst_pulses", 64'({rf_we, csr_we, ertn_flush, wb_ex, refetch_flush}), 64'd0);
        idle(3);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
